// File: rtl/fb_draw_engine.sv
// fb_draw_engine
// Command-driven pixel writer for the back buffer of a double-buffered
// framebuffer. Accepts CLEAR / RECT / SWAP / NOP commands over a valid/ready
// handshake and emits one pixel write per clock on the framebuffer write port.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only in IDLE, low during reset)
//   cmd_op            0=CLEAR, 1=RECT, 2=SWAP, 3=NOP
//   cmd_x0/x1/y0/y1   inclusive rectangle corners (x1/y1 clipped to the screen)
//   cmd_color         fill value for CLEAR and RECT
//   mem_addr/din/wen  framebuffer write port, address = y*RES_X + x
//   swap_buf          one-cycle buffer swap request
//   frame_start       display frame-start indication, only watched in WAIT_FRAME
//   busy              command in progress
module fb_draw_engine #(
    parameter int RES_X      = 320,
    parameter int RES_Y      = 240,
    parameter int MEM_WIDTH  = 8,
    parameter int ADDR_WIDTH = $clog2(RES_X*RES_Y),
    parameter int X_BITS     = $clog2(RES_X),
    parameter int Y_BITS     = $clog2(RES_Y)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [X_BITS-1:0]     cmd_x0,
    input  logic [X_BITS-1:0]     cmd_x1,
    input  logic [Y_BITS-1:0]     cmd_y0,
    input  logic [Y_BITS-1:0]     cmd_y1,
    input  logic [MEM_WIDTH-1:0]  cmd_color,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_WIDTH-1:0]  din,
    output logic                  wen,
    output logic                  swap_buf,
    input  logic                  frame_start,
    output logic                  busy
);

    localparam logic [1:0] OP_CLEAR = 2'd0;
    localparam logic [1:0] OP_RECT  = 2'd1;
    localparam logic [1:0] OP_SWAP  = 2'd2;
    localparam logic [1:0] OP_NOP   = 2'd3;

    localparam logic [X_BITS-1:0]     X_MAX      = X_BITS'(RES_X - 1);
    localparam logic [Y_BITS-1:0]     Y_MAX      = Y_BITS'(RES_Y - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(RES_X);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FILL       = 2'd1,
        SWAP       = 2'd2,
        WAIT_FRAME = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [X_BITS-1:0]       x_reg, x_next;
    logic [Y_BITS-1:0]       y_reg, y_next;
    logic [X_BITS-1:0]       x0_reg, x0_next;
    logic [X_BITS-1:0]       xe_reg, xe_next;
    logic [Y_BITS-1:0]       ye_reg, ye_next;
    logic [ADDR_WIDTH-1:0]   row_base_reg, row_base_next;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg, mem_addr_next;
    logic [MEM_WIDTH-1:0]    din_reg, din_next;
    logic                    wen_reg, wen_next;
    logic                    swap_reg, swap_next;

    // Command decode at acceptance: CLEAR becomes a full-screen rectangle,
    // RECT right/bottom edges are clipped to the screen.
    logic [X_BITS-1:0]       acc_x0, acc_xe;
    logic [Y_BITS-1:0]       acc_y0, acc_ye;
    logic                    acc_empty;
    logic [ADDR_WIDTH-1:0]   acc_row_base;

    always_comb begin
        acc_x0 = cmd_x0;
        acc_y0 = cmd_y0;
        acc_xe = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
        acc_ye = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
        if (cmd_op == OP_CLEAR) begin
            acc_x0 = '0;
            acc_y0 = '0;
            acc_xe = X_MAX;
            acc_ye = Y_MAX;
        end
        acc_empty    = (acc_x0 > acc_xe) || (acc_y0 > acc_ye);
        // Constant-coefficient product, evaluated once per command; the
        // per-pixel address path only adds.
        acc_row_base = ADDR_WIDTH'(acc_y0) * ROW_STRIDE;
    end

    // State and registered-output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            x_reg        <= '0;
            y_reg        <= '0;
            x0_reg       <= '0;
            xe_reg       <= '0;
            ye_reg       <= '0;
            row_base_reg <= '0;
            mem_addr_reg <= '0;
            din_reg      <= '0;
            wen_reg      <= 1'b0;
            swap_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            x0_reg       <= x0_next;
            xe_reg       <= xe_next;
            ye_reg       <= ye_next;
            row_base_reg <= row_base_next;
            mem_addr_reg <= mem_addr_next;
            din_reg      <= din_next;
            wen_reg      <= wen_next;
            swap_reg     <= swap_next;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_next    = state_reg;
        x_next        = x_reg;
        y_next        = y_reg;
        x0_next       = x0_reg;
        xe_next       = xe_reg;
        ye_next       = ye_reg;
        row_base_next = row_base_reg;
        mem_addr_next = mem_addr_reg;
        din_next      = din_reg;
        wen_next      = 1'b0;
        swap_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_CLEAR, OP_RECT: begin
                            // An empty rectangle still passes through FILL
                            // with wen low, giving the single busy cycle.
                            state_next = FILL;
                            if (!acc_empty) begin
                                x_next        = acc_x0;
                                y_next        = acc_y0;
                                x0_next       = acc_x0;
                                xe_next       = acc_xe;
                                ye_next       = acc_ye;
                                row_base_next = acc_row_base;
                                mem_addr_next = acc_row_base + ADDR_WIDTH'(acc_x0);
                                din_next      = cmd_color;
                                wen_next      = 1'b1;
                            end
                        end
                        OP_SWAP: begin
                            state_next = SWAP;
                            swap_next  = 1'b1;
                        end
                        OP_NOP: begin
                            state_next = FILL;
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end

            FILL: begin
                // wen_reg low in FILL means a no-write pass (NOP / empty).
                if (!wen_reg) begin
                    state_next = IDLE;
                end else if (x_reg == xe_reg && y_reg == ye_reg) begin
                    state_next = IDLE;
                end else if (x_reg == xe_reg) begin
                    x_next        = x0_reg;
                    y_next        = y_reg + Y_BITS'(1);
                    row_base_next = row_base_reg + ROW_STRIDE;
                    mem_addr_next = row_base_reg + ROW_STRIDE + ADDR_WIDTH'(x0_reg);
                    wen_next      = 1'b1;
                end else begin
                    x_next        = x_reg + X_BITS'(1);
                    mem_addr_next = mem_addr_reg + ADDR_WIDTH'(1);
                    wen_next      = 1'b1;
                end
            end

            SWAP: begin
                state_next = WAIT_FRAME;
            end

            WAIT_FRAME: begin
                if (frame_start) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // Outputs; strobes are forced low while reset is asserted.
    always_comb begin
        cmd_ready = !rst && (state_reg == IDLE);
        busy      = !rst && (state_reg != IDLE);
        wen       = wen_reg && !rst;
        swap_buf  = swap_reg && !rst;
        mem_addr  = mem_addr_reg;
        din       = din_reg;
    end

endmodule

// File: doc/fb_draw_engine.md
# fb_draw_engine

Command-driven pixel writer that fills the back buffer of the double-buffered VGA framebuffer. It accepts clear, rectangle-fill and swap commands over a valid/ready handshake and emits one pixel write per clock on the framebuffer write port (`mem_addr`/`din`/`wen`). A swap command raises `swap_buf` for one cycle, then holds off further commands until the display side has committed the buffer flip at frame start. It sits between a host or sequencer and the framebuffer write port.

## Interface
- RES_X, 320, framebuffer width in pixels
- RES_Y, 240, framebuffer height in pixels
- MEM_WIDTH, 8, pixel word width (0b00RRGGBB in the low 6 bits)
- ADDR_WIDTH, $clog2(RES_X*RES_Y), framebuffer address width
- X_BITS, $clog2(RES_X), command X coordinate width
- Y_BITS, $clog2(RES_Y), command Y coordinate width

- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high; clock is clk
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_op  in  2  0=CLEAR, 1=RECT, 2=SWAP, 3=NOP
- cmd_x0, cmd_x1  in  X_BITS  rectangle left and right columns, inclusive
- cmd_y0, cmd_y1  in  Y_BITS  rectangle top and bottom rows, inclusive
- cmd_color  in  MEM_WIDTH  fill value for CLEAR and RECT
- mem_addr  out  ADDR_WIDTH  write address, y*RES_X+x
- din  out  MEM_WIDTH  write data
- wen  out  1  write strobe, one pixel per cycle
- swap_buf  out  1  one-cycle swap request to the double buffer
- frame_start  in  1  display frame-start indication; may stay high for several consecutive cycles
- busy  out  1  command in progress; equals !cmd_ready outside reset

## Operation
- States: IDLE, FILL, SWAP, WAIT_FRAME.
- cmd_ready is high only in IDLE, and is forced to 0 while rst is high. A command is accepted when cmd_valid and cmd_ready are both high. All cmd_* fields are captured on acceptance and may change afterwards.
- CLEAR: treated as RECT (0,0)-(RES_X-1,RES_Y-1).
- RECT clipping at acceptance:
  - xe = min(x1, RES_X-1), ye = min(y1, RES_Y-1).
  - If x0>xe or y0>ye, the rectangle is empty: no writes; go IDLE next cycle.
- FILL: raster order, x fastest then y.
  - Each write is the address/data pair for the current pixel, with din = captured color.
  - Address is kept incrementally as row_base + x. row_base starts at y0*RES_X and advances by RES_X per row. No runtime multiplier.
  - After the write of (xe,ye), go IDLE.
- SWAP: assert swap_buf for exactly one cycle, then go WAIT_FRAME.
- WAIT_FRAME: leave for IDLE on the first cycle in WAIT_FRAME with frame_start=1. frame_start is ignored in every other state.
- NOP: accepted, no output activity, return to IDLE.
- Registered outputs: mem_addr, din, wen, swap_buf.
  - When wen=0, mem_addr and din hold their last value.
- Reset: state IDLE. mem_addr=0, din=0, wen=0, swap_buf=0, cmd_ready=0 during reset, busy=0.
- Reset mid-FILL or mid-WAIT_FRAME aborts immediately. wen=0 in the first cycle after reset; the unfinished command is not resumed.

## Timing
- Acceptance at clock edge of cycle T.
- RECT/CLEAR with N=(xe-x0+1)*(ye-y0+1) pixels:
  - wen=1 in cycles T+1 through T+N, with pixel k (0-based) in cycle T+1+k.
  - cmd_ready=1 again in cycle T+N+1. Back-to-back commands therefore insert one idle cycle.
- Empty RECT and NOP: busy in T+1 only; cmd_ready=1 in T+2.
- SWAP:
  - swap_buf=1 in cycle T+1 only.
  - WAIT_FRAME begins in cycle T+2. If W≥T+2 is the first cycle with frame_start=1, cmd_ready=1 in W+1.
  - This guarantees the downstream swap latch is already set when frame_start is sampled, so the first write after the swap lands in the new back buffer.
- CLEAR at 320x240 takes 76800 cycles. Max address = RES_X*RES_Y-1; the address never wraps.

## Test plan
- CLEAR, color 0x3F, accepted at T -> 76800 writes in cycles T+1..T+76800 with addresses 0..76799 consecutive and din=0x3F; cmd_ready high at T+76801.
- RECT (10,5)-(12,6), color 0x30 -> exactly 6 writes to addresses 1610, 1611, 1612, 1930, 1931, 1932 in that order.
- RECT (318,238)-(400,255), color 0x0C -> clipped to 4 writes: 76478, 76479, 76798, 76799.
- RECT (20,5)-(10,9) -> no wen; cmd_ready low for one cycle, high at T+2.
- SWAP accepted at T with frame_start=1 in T..T+1 and again at T+20 -> swap_buf=1 only in T+1, and frame_start in T+1 is ignored. frame_start is sampled in WAIT_FRAME from T+2; if it is still high at T+2, cmd_ready=1 at T+3, otherwise cmd_ready=1 at T+21. A second command held valid is not accepted earlier.
- rst asserted for 1 cycle mid-CLEAR -> wen=0, swap_buf=0, cmd_ready=0 while rst is high; cmd_ready=1 the cycle after; no further writes without a new command.
